// File: rtl/chan_mux_rr.sv
// chan_mux_rr: NCH-to-1 stream mux, fixed-select (mode=0) or round-robin (mode=1); 1-cycle registered output.
// Backpressure: in_ready only when the output register is empty or draining; en_n=1 flushes it (CHMUX_HOLD_EN: holds it).
module chan_mux_rr #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_n,
  input  logic                  mode,
  input  logic [SELW-1:0]       sel,
  input  logic [NCH*WIDTH-1:0]  in_data,
  input  logic [NCH-1:0]        in_valid,
  output logic [NCH-1:0]        in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SELW-1:0]       out_ch
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  logic [SELW-1:0]  last;
  logic [SELW-1:0]  cand;
  logic [SELW-1:0]  rr_ch;
  logic             rr_found;
  logic             cand_ok;
  logic             cand_vld;
  logic             load_ok;
  logic             xfer;
  logic [WIDTH-1:0] cand_data;

  assign load_ok = !en_n && (!out_valid || out_ready);

  // Lowest valid index above last wins; otherwise wrap to the lowest valid index at or below last.
  always_comb begin
    rr_ch    = '0;
    rr_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (in_valid[i] && (i <= int'(last))) begin
        rr_ch    = SELW'(i);
        rr_found = 1'b1;
      end
    end
    for (int i = NCH - 1; i >= 0; i--) begin
      if (in_valid[i] && (i > int'(last))) begin
        rr_ch    = SELW'(i);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    if (mode) begin
      cand    = rr_ch;
      cand_ok = rr_found;
    end else begin
      cand    = (int'(sel) >= NCH) ? LAST_CH : sel;
      cand_ok = 1'b1;
    end
  end

  always_comb begin
    in_ready  = '0;
    cand_data = '0;
    cand_vld  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (SELW'(i) == cand) begin
        in_ready[i] = load_ok && cand_ok;
        cand_data   = in_data[i*WIDTH +: WIDTH];
        cand_vld    = in_valid[i];
      end
    end
  end

  assign xfer = cand_ok && cand_vld && load_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      last      <= LAST_CH;
    end else if (xfer) begin
      out_data  <= cand_data;
      out_ch    <= cand;
      out_valid <= 1'b1;
      last      <= cand;
    end else if (en_n) begin
`ifdef CHMUX_HOLD_EN
      if (out_valid && out_ready) out_valid <= 1'b0;
`else
      out_data  <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/chan_mux_rr.md
# chan_mux_rr

Registered N-channel stream multiplexer with valid/ready handshakes. It supersedes the fixed 4-bit, 4-input combinational selector. The block adds parametrised width and channel count, a fixed-select or round-robin arbitration mode, and a one-entry output register. It sits between several producer channels and a single downstream consumer in the datapath, and it keeps the active-low enable semantics of the older selector: enabled passes data, disabled drives zero.

## Interface
Parameters:
- WIDTH, 4: data bits per channel.
- NCH, 4: number of input channels (2..16).
- SELW, 2: select/channel-index width, at least clog2(NCH).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en_n  in  1  active-low enable; 0 = operate, 1 = disabled.
- mode  in  1  0 = fixed select via sel, 1 = round-robin.
- sel  in  SELW  channel index used when mode=0.
- in_data  in  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel valid.
- in_ready  out  NCH  per-channel ready; combinational.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream ready.
- out_ch  out  SELW  index of the channel held in the output register.

## Operation
- Reset:
  - out_data=0, out_valid=0, out_ch=0.
  - Round-robin pointer last=NCH-1, so channel 0 has top priority first.
- Output register can load: load_ok = !en_n && (!out_valid || out_ready).
- Candidate channel:
  - mode=0: sel. If sel>=NCH, the candidate is NCH-1 (default arm).
  - mode=1: first channel with in_valid=1, scanning last+1, last+2, … modulo NCH.
- Outputs and handshake:
  - in_ready[i] = load_ok && (i == candidate). All other bits are 0.
  - Transfer on channel i occurs when in_valid[i] && in_ready[i]. On transfer: out_data<=in_data[i], out_ch<=i, out_valid<=1, last<=i.
  - If out_valid && out_ready and there is no new transfer, out_valid<=0. out_data and out_ch hold their values.
- Other rules:
  - The pointer updates on every transfer in either mode. A mode switch takes effect on the next cycle's candidate.
  - mode=0 with the selected channel invalid: no transfer, and no fallback to other channels.
  - mode=1 with no channel valid: no transfer, and the pointer is unchanged.
- Disabled (en_n=1): in_ready is all zero; the output side behaves per Configuration.
- rst takes priority over every other event, including a transfer in the same cycle.

## Timing
- Latency: in handshake at edge N gives out_valid=1 with the data after edge N, one cycle.
- Throughput: one word per cycle while out_ready=1 and a candidate is valid. A simultaneous drain and load in the same cycle is allowed.
- out_valid=1 && out_ready=0: out_data, out_valid and out_ch stay stable, and in_ready is all zero.
- Round-robin fairness: with all NCH channels valid continuously, grants cycle 0,1,…,NCH-1,0 with no channel skipped.
- A rst asserted mid-stream discards the registered word. out_valid=0 on the cycle after rst is sampled.

## Configuration
- Macro CHMUX_HOLD_EN.
- Defined: en_n=1 pauses the block. The output register holds its contents and out_valid, and a pending word is still drained by out_ready. No new loads occur.
- Undefined (default): en_n=1 flushes the output. On the next edge out_data=0, out_valid=0 and out_ch=0, matching the legacy forced-zero output.

## Test plan
- Reset and fixed select: after rst, drive mode=0, sel=2, WIDTH=4, ch2=4'hA valid, out_ready=1. Expect in_ready=4'b0100, then out_data=4'hA, out_ch=2, out_valid=1 one cycle later.
- Out-of-range select: NCH=3, SELW=2, sel=3, ch2=4'h5 valid. Expect channel 2 granted and out_data=4'h5.
- Round-robin fairness: mode=1, all 4 channels valid with ch0..3=1,2,3,4, out_ready=1 for 8 cycles. Expect out_ch sequence 0,1,2,3,0,1,2,3 and out_data 1,2,3,4,1,2,3,4.
- Backpressure: load ch1=4'h7, then hold out_ready=0 for 3 cycles. Expect out_data=4'h7 and out_valid=1 stable, in_ready=0. Set out_ready=1 and expect a drain plus the next load in the same cycle.
- Disable: with out_valid=1 and out_data=4'h9, set en_n=1.
  - Macro undefined: out_data=0 and out_valid=0 next cycle.
  - CHMUX_HOLD_EN defined: out_data=4'h9 held until out_ready=1, then out_valid=0.
  - Both builds: in_ready=0 throughout.
- Reset mid-stream: assert rst in the same cycle as a transfer on ch3. Expect out_valid=0 and out_data=0 next cycle, and the next round-robin grant goes to ch0.
